// File: rtl/r_seq_ctrl_if.sv
// ROM bus between the R-type sequencer and its synchronous instruction ROM.
// The sequencer presents a word address; the ROM returns the word one cycle later.
interface r_seq_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       inst_code;

  modport master (
    output rom_addr,
    input  inst_code
  );

  modport slave (
    input  rom_addr,
    output inst_code
  );
endinterface

// File: rtl/r_seq_ctrl.sv
// Four-cycle R-type sequencer: fetch, decode, exec, write-back.
// Owns the PC and the ROM address, and supports run, single-step and halt.
module r_seq_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  r_seq_ctrl_if.master     rom,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [ADDR_W+1:0] PC_STEP = (ADDR_W+2)'(4);

  state_t            r_state;
  logic [ADDR_W+1:0] r_pc;
  logic [31:0]       r_ir;
  logic [2:0]        r_alu_op;
  logic              r_wr_ok;
  logic              r_reg_we;
  logic              r_busy;
  logic              r_halted;
  logic              r_illegal;
  logic              r_run_q;
  logic [CNT_W-1:0]  r_cnt;

  logic [5:0]        w_opc;
  logic [5:0]        w_funct;
  logic [4:0]        w_rd;
  logic              w_valid;
  logic [2:0]        w_op;
  logic              w_nop;
  logic              w_halt;
  logic              w_start;
  logic              w_cnt_sat;

  assign w_opc     = rom.inst_code[31:26];
  assign w_funct   = rom.inst_code[5:0];
  assign w_rd      = rom.inst_code[15:11];
  assign w_nop     = (rom.inst_code == 32'd0);
  assign w_halt    = (rom.inst_code == HALT_WORD);
  assign w_cnt_sat = &r_cnt;

  // Step mode only starts on a fresh rising edge of run.
  assign w_start = step_mode ? (run & ~r_run_q) : run;

  always_comb begin
    w_valid = 1'b0;
    w_op    = 3'b000;
    if (w_opc == 6'd0) begin
      unique case (1'b1)
        (w_funct == 6'h20): begin w_valid = 1'b1; w_op = 3'b010; end
        (w_funct == 6'h22): begin w_valid = 1'b1; w_op = 3'b110; end
        (w_funct == 6'h24): begin w_valid = 1'b1; w_op = 3'b000; end
        (w_funct == 6'h25): begin w_valid = 1'b1; w_op = 3'b001; end
        (w_funct == 6'h26): begin w_valid = 1'b1; w_op = 3'b011; end
        (w_funct == 6'h27): begin w_valid = 1'b1; w_op = 3'b100; end
        (w_funct == 6'h2A): begin w_valid = 1'b1; w_op = 3'b111; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_alu_op  <= '0;
      r_wr_ok   <= 1'b0;
      r_reg_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_run_q   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_run_q <= run;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir <= rom.inst_code;
          if (w_halt) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state  <= S_EXEC;
            r_alu_op <= w_op;
            r_wr_ok  <= w_valid && (w_rd != 5'd0);
            if (!w_valid && !w_nop) begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_state  <= S_WB;
          r_reg_we <= r_wr_ok;
        end
        S_WB: begin
          r_reg_we <= 1'b0;
          r_pc     <= r_pc + PC_STEP;
          if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (!step_mode && run) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HALT: ;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rom.rom_addr = r_pc[ADDR_W+1:2];
  assign pc           = 32'(r_pc);
  assign ir           = r_ir;
  assign rs_addr      = r_ir[25:21];
  assign rt_addr      = r_ir[20:16];
  assign rd_addr      = r_ir[15:11];
  assign alu_op       = r_alu_op;
  assign reg_we       = r_reg_we;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign illegal      = r_illegal;
  assign inst_cnt     = r_cnt;

endmodule

// File: tb/tb_r_seq_ctrl.sv
// Bench for r_seq_ctrl: a program-level reference model feeds a scoreboard
// that a negedge monitor drains on every write strobe and every retirement.
module tb_r_seq_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step_mode;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [2:0]  alu_op;
  logic        reg_we;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [15:0] inst_cnt;

  logic [31:0] rom [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r_seq_ctrl_if #(.ADDR_W(6)) rif ();

  always @(posedge clk) rif.inst_code <= rom[rif.rom_addr];

  r_seq_ctrl #(.ADDR_W(6), .CNT_W(16), .HALT_WORD(HALT)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_mode (step_mode),
    .rom       (rif.master),
    .pc        (pc),
    .ir        (ir),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .inst_cnt  (inst_cnt)
  );

  logic [5:0] FUN [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [2:0] OPS [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111};

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  op;
    logic [31:0] pc;
  } we_e;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [15:0] cnt;
    logic        ill;
    logic [2:0]  op;
  } ret_e;

  we_e  we_q [$];
  ret_e ret_q [$];

  int          m_pc;
  logic [15:0] m_cnt;
  logic        m_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction at the model PC.
  task automatic model_step(output bit hl);
    logic [31:0] w;
    bit          v;
    logic [2:0]  op;
    w  = rom[m_pc / 4];
    hl = 1'b0;
    if (w == HALT) begin
      hl = 1'b1;
      return;
    end
    v  = 1'b0;
    op = 3'b000;
    if (w[31:26] == 6'd0) begin
      for (int k = 0; k < 7; k++) begin
        if (w[5:0] == FUN[k]) begin
          v  = 1'b1;
          op = OPS[k];
        end
      end
    end
    if (v && w[15:11] != 5'd0) begin
      we_q.push_back('{rd: w[15:11], rs: w[25:21], rt: w[20:16], op: op, pc: 32'(m_pc)});
    end
    if (!v && w != 32'd0) m_ill = 1'b1;
    m_pc = (m_pc + 4) % 256;
    if (m_cnt != 16'hFFFF) m_cnt++;
    ret_q.push_back('{pc: 32'(m_pc), ir: w, cnt: m_cnt, ill: m_ill, op: op});
  endtask

  function automatic logic [31:0] rop(input int k, input logic [4:0] rd);
    logic [4:0] rs;
    logic [4:0] rt;
    rs = 5'($urandom);
    rt = 5'($urandom);
    return {6'd0, rs, rt, rd, 5'd0, FUN[k]};
  endfunction

  task automatic do_reset();
    rst       = 1'b0;
    run       = 1'b0;
    step_mode = 1'b0;
    repeat (2) @(negedge clk);
    we_q.delete();
    ret_q.delete();
    m_pc  = 0;
    m_cnt = '0;
    m_ill = 1'b0;
  endtask

  task automatic wait_for(input string nm, input int kind, input int arg, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0: ok = (inst_cnt == 16'(arg));
        1: ok = halted;
        2: ok = !busy;
        3: ok = reg_we;
        default: ok = 1'b1;
      endcase
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic run_model_to_halt();
    bit hl;
    hl = 1'b0;
    for (int i = 0; i < 200 && !hl; i++) model_step(hl);
  endtask

  // Scoreboard monitor.
  initial begin
    logic [15:0] prev_cnt;
    logic        prev_we;
    we_e         e;
    ret_e        r;
    prev_cnt = '0;
    prev_we  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_cnt = '0;
        prev_we  = 1'b0;
      end else begin
        if (reg_we) begin
          chk("we_single_cycle", 32'(prev_we), 32'd0);
          if (we_q.size() == 0) begin
            chk("we_unexpected", 32'(reg_we), 32'd0);
          end else begin
            e = we_q.pop_front();
            chk("we_rd", 32'(rd_addr), 32'(e.rd));
            chk("we_rs", 32'(rs_addr), 32'(e.rs));
            chk("we_rt", 32'(rt_addr), 32'(e.rt));
            chk("we_op", 32'(alu_op), 32'(e.op));
            chk("we_pc", pc, e.pc);
          end
        end
        if (inst_cnt != prev_cnt) begin
          if (ret_q.size() == 0) begin
            chk("ret_unexpected", 32'(inst_cnt), 32'(prev_cnt));
          end else begin
            r = ret_q.pop_front();
            chk("ret_pc", pc, r.pc);
            chk("ret_ir", ir, r.ir);
            chk("ret_cnt", 32'(inst_cnt), 32'(r.cnt));
            chk("ret_ill", 32'(illegal), 32'(r.ill));
            chk("ret_op", 32'(alu_op), 32'(r.op));
          end
        end
        prev_cnt = inst_cnt;
        prev_we  = reg_we;
      end
    end
  end

  initial begin
    int k;
    logic [31:0] t;
    logic [31:0] hold_pc;
    logic [15:0] hold_cnt;
    bit hl;

    // Reset state
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    chk("rst_cnt", 32'(inst_cnt), 32'd0);
    chk("rst_flags", {28'd0, reg_we, busy, halted, illegal}, 32'd0);

    // ADD first, then the remaining six ops shuffled, then HALT
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h0022_1820;
    for (int i = 1; i < 7; i++) rom[i] = rop(i, 5'($urandom));
    for (int i = 1; i < 7; i++) begin
      k = $urandom_range(1, 6);
      t = rom[i]; rom[i] = rom[k]; rom[k] = t;
    end
    rom[7] = HALT;
    run_model_to_halt();
    rst = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("first_we_cycle", 32'(reg_we), 32'(c == 4));
    end
    chk("first_rd", 32'(rd_addr), 32'd3);
    chk("first_op", 32'(alu_op), 32'b010);
    wait_for("halt_timeout", 1, 0, 200);
    chk("halt_pc", pc, 32'h1C);
    chk("halt_cnt", 32'(inst_cnt), 32'd7);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_sb_empty", 32'(we_q.size() + ret_q.size()), 32'd0);
    hold_pc  = pc;
    hold_cnt = inst_cnt;
    for (int i = 0; i < 12; i++) begin
      run       = 1'($urandom);
      step_mode = 1'($urandom);
      @(negedge clk);
    end
    chk("halt_hold_pc", pc, hold_pc);
    chk("halt_hold_cnt", 32'(inst_cnt), 32'(hold_cnt));
    chk("halt_hold_flags", {30'd0, halted, reg_we}, 32'd2);

    // Illegal, nop and rd=0 sequence
    do_reset();
    for (int i = 0; i < 64; i++) rom[i] = HALT;
    rom[0] = rop(1, 5'd5);
    rom[1] = 32'h8C01_0000;
    rom[2] = 32'd0;
    rom[3] = rop(3, 5'd0);
    run_model_to_halt();
    rst = 1'b1;
    run = 1'b1;
    wait_for("ill_timeout", 1, 0, 200);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_pc", pc, 32'h10);
    chk("ill_cnt", 32'(inst_cnt), 32'd4);
    chk("ill_sb_empty", 32'(we_q.size() + ret_q.size()), 32'd0);

    // Single step with random program
    do_reset();
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 2))
        0: rom[i] = rop($urandom_range(0, 6), 5'($urandom));
        1: rom[i] = 32'd0;
        default: begin
          rom[i] = $urandom;
          if (rom[i] == HALT) rom[i] = 32'd0;
        end
      endcase
    end
    step_mode = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      run = 1'b1;
      model_step(hl);
      repeat (20) @(negedge clk);
      chk("step_cnt", 32'(inst_cnt), 32'(p + 1));
      chk("step_idle", 32'(busy), 32'd0);
      chk("step_sb_empty", 32'(we_q.size() + ret_q.size()), 32'd0);
      run = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Free-run wrap over 64 nops, then drop run
    do_reset();
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    for (int i = 0; i < 67; i++) model_step(hl);
    rst = 1'b1;
    run = 1'b1;
    wait_for("wrap_timeout", 0, 66, 400);
    run = 1'b0;
    wait_for("wrap_idle_timeout", 2, 0, 20);
    repeat (10) @(negedge clk);
    chk("wrap_cnt", 32'(inst_cnt), 32'd67);
    chk("wrap_pc", pc, 32'h0C);
    chk("wrap_sb_empty", 32'(we_q.size() + ret_q.size()), 32'd0);

    // Reset during write-back
    do_reset();
    for (int i = 0; i < 64; i++) rom[i] = HALT;
    rom[0] = rop(0, 5'd3);
    model_step(hl);
    void'(ret_q.pop_back());
    rst = 1'b1;
    run = 1'b1;
    wait_for("wb_timeout", 3, 0, 20);
    #1 rst = 1'b0;
    #1;
    chk("wbrst_we", 32'(reg_we), 32'd0);
    chk("wbrst_pc", pc, 32'd0);
    chk("wbrst_cnt", 32'(inst_cnt), 32'd0);
    run = 1'b0;
    @(negedge clk);
    m_pc  = 0;
    m_cnt = '0;
    m_ill = 1'b0;
    we_q.delete();
    ret_q.delete();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("wbrst_idle", {30'd0, busy, reg_we}, 32'd0);
    run_model_to_halt();
    run = 1'b1;
    wait_for("wbrst_halt_timeout", 1, 0, 50);
    chk("wbrst_final_pc", pc, 32'd4);
    chk("wbrst_final_cnt", 32'(inst_cnt), 32'd1);
    chk("wbrst_sb_empty", 32'(we_q.size() + ret_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
